// File: rtl/segment_sampler.sv
// segment_sampler: draws a uniform random value from a signed segment by LFSR rejection sampling.
// Ports: in_clk/in_reset (sync active-high); request in_valid/out_ready with in_start, in_end,
// in_type (00 bounded, 01 no upper, 10 no lower, 11 empty), in_assignment_old; result
// out_valid/in_result_ready with out_assignment_new and out_timeout (MAX_TRIES fallback).
// Optional `SEGMENT_SAMPLER_STATS_EN adds saturating out_reject_count/out_sample_count.
module segment_sampler #(
  parameter int WIDTH = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int MAX_TRIES = 15
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_start,
  input  logic [WIDTH-1:0] in_end,
  input  logic [1:0]       in_type,
  input  logic [WIDTH-1:0] in_assignment_old,
  output logic             out_valid,
  input  logic             in_result_ready,
  output logic [WIDTH-1:0] out_assignment_new,
  output logic             out_timeout
`ifdef SEGMENT_SAMPLER_STATS_EN
  ,
  output logic [15:0]      out_reject_count,
  output logic [15:0]      out_sample_count
`endif
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0] MAX_T = 8'(MAX_TRIES);
  typedef enum logic [1:0] {IDLE, PREP, DRAW, DONE} state_t;
  state_t state, state_nx;
  logic signed [WIDTH-1:0] start_q, end_q, lo, hi;
  logic [WIDTH-1:0] old_q, span, mask, r;
  logic [WIDTH:0] range;
  logic [1:0] type_q;
  logic [15:0] lfsr, lfsr_nx;
  logic [7:0] tries;
  logic empty, hit, give_up;
  // Registered request stays constant until the next accept, so lo/hi/range/mask
  // are derived combinationally from it and are stable throughout PREP and DRAW.
  always_comb begin
    lo = (type_q == 2'b10) ? SMIN : start_q;
    hi = (type_q == 2'b01) ? SMAX : end_q;
    empty = (type_q == 2'b11) || (lo > hi);
    span = hi - lo;
    range = {1'b0, span} + 1'b1;
    mask = span;
    for (int i = 1; i < WIDTH; i = i * 2) mask = mask | (mask >> i);
    r = lfsr[WIDTH-1:0] & mask;
    hit = {1'b0, r} < range;
    give_up = (tries + 8'd1) == MAX_T;
    lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = in_valid ? PREP : IDLE;
      PREP: state_nx = empty ? DONE : DRAW;
      DRAW: state_nx = (hit || give_up) ? DONE : DRAW;
      DONE: state_nx = in_result_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign out_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state <= IDLE;
      out_assignment_new <= '0;
      out_timeout <= 1'b0;
      tries <= '0;
      lfsr <= SEED;
      start_q <= '0;
      end_q <= '0;
      old_q <= '0;
      type_q <= 2'b11;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        start_q <= in_start;
        end_q <= in_end;
        type_q <= in_type;
        old_q <= in_assignment_old;
        tries <= '0;
      end
      if (state == PREP && empty) begin
        out_assignment_new <= old_q;
        out_timeout <= 1'b0;
      end
      if (state == DRAW) begin
        lfsr <= lfsr_nx;
        if (hit) begin
          out_assignment_new <= lo + r;
          out_timeout <= 1'b0;
        end else begin
          tries <= tries + 8'd1;
          if (give_up) begin
            out_assignment_new <= lo;
            out_timeout <= 1'b1;
          end
        end
      end
    end
  end
`ifdef SEGMENT_SAMPLER_STATS_EN
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      out_reject_count <= '0;
      out_sample_count <= '0;
    end else begin
      if (state == DRAW && !hit && out_reject_count != 16'hFFFF) out_reject_count <= out_reject_count + 16'd1;
      if (out_valid && in_result_ready && out_sample_count != 16'hFFFF) out_sample_count <= out_sample_count + 16'd1;
    end
  end
`endif
endmodule

// File: doc/segment_sampler.md
SEGMENT_SAMPLER -- requirements
Module: segment_sampler

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, two's-complement width of integer assignments (legal range 2..16).
REQ-002 SHALL provide parameter LFSR_SEED, default 16'hACE1, initial LFSR state; a value of 0 SHALL load 16'hACE1 instead.
REQ-003 SHALL provide parameter MAX_TRIES, default 15, rejection-draw limit per request (1..255).
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 Ports SHALL be:
- in_clk  input  1  rising-edge clock
- in_reset  input  1  synchronous active-high reset
- in_valid  input  1  segment request present
- out_ready  output  1  block can accept a request
- in_start  input  WIDTH  segment lower bound (signed)
- in_end  input  WIDTH  segment upper bound (signed)
- in_type  input  2  00 bounded, 01 no upper bound, 10 no lower bound, 11 empty
- in_assignment_old  input  WIDTH  current variable value
- out_valid  output  1  result present
- in_result_ready  input  1  consumer accepts result
- out_assignment_new  output  WIDTH  sampled value
- out_timeout  output  1  result produced by MAX_TRIES fallback

Function
REQ-006 States SHALL be IDLE, PREP, DRAW, DONE.
REQ-007 out_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && out_ready on a clock edge, and all inputs are registered then.
REQ-008 On accept, IDLE -> PREP.
REQ-009 PREP SHALL form lo/hi: type 00 lo=start, hi=end; 01 lo=start, hi=+max; 10 lo=-min, hi=end; 11 empty.
REQ-010 PREP SHALL treat type 00/01/10 with lo > hi (signed) as empty.
REQ-011 For an empty segment, PREP -> DONE with out_assignment_new = registered in_assignment_old, out_timeout=0.
REQ-012 Otherwise PREP SHALL compute range = hi - lo + 1 in WIDTH+1 unsigned bits and mask = smallest 2^k-1 >= range-1, then go to DRAW.
REQ-013 LFSR SHALL be 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advanced exactly one step per cycle spent in DRAW, held otherwise.
REQ-014 In DRAW each cycle r = lfsr[WIDTH-1:0] & mask (current state, before advance); if r < range, result = lo + r (WIDTH bits), -> DONE.
REQ-015 If r >= range, the try counter SHALL increment; when it reaches MAX_TRIES, result = lo, out_timeout=1, -> DONE.
REQ-016 Range 1 (lo == hi) SHALL yield lo after exactly one DRAW cycle, out_timeout=0.
REQ-017 DONE SHALL assert out_valid with stable out_assignment_new/out_timeout until in_result_ready; on out_valid && in_result_ready, -> IDLE.
REQ-018 Latency SHALL be: accept to out_valid = 2 cycles (empty) or 2 + number of DRAW cycles (non-empty, 1..MAX_TRIES).
REQ-019 in_valid outside IDLE SHALL be ignored; no queuing.
REQ-020 Try counter SHALL clear on each accept.

Reset
REQ-021 in_reset SHALL force IDLE, out_ready=1, out_valid=0, out_assignment_new=0, out_timeout=0, try counter=0, LFSR=seed (REQ-002), overriding all other inputs in that cycle.
REQ-022 Reset in any state mid-operation SHALL abandon the request without producing a result.

Configuration
REQ-023 With SEGMENT_SAMPLER_STATS_EN defined, the block SHALL add outputs out_reject_count (16) and out_sample_count (16): rejected draws and delivered results, saturating at 16'hFFFF, cleared by reset.
REQ-024 Without SEGMENT_SAMPLER_STATS_EN, these ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-025 Type 11, old=8'sd5 -> out_valid 2 cycles after accept, new=5, timeout=0.
REQ-026 Type 00, start=-3, end=-3 -> new=-3 after 3 cycles, timeout=0.
REQ-027 Type 00, start=2, end=9, 1000 requests -> every new in [2,9], all 8 values seen, timeout never set.
REQ-028 Type 00, start=10, end=4 -> treated empty, new=old.
REQ-029 MAX_TRIES=1, start=0, end=4 (mask 7), LFSR forced to yield r=6 -> new=0, timeout=1.
REQ-030 Hold in_result_ready=0 for 5 cycles in DONE -> outputs stable, out_ready=0; reset asserted mid-DRAW -> next cycle IDLE, out_valid=0.
